// File: rtl/mipscpu_mc.sv
// mipscpu_mc: parametrised multicycle MIPS-subset execution core
// with a busy/done/illegal handshake and a host data-memory port.
module mipscpu_mc #(
    parameter int DATA_W    = 32,
    parameter int REG_COUNT = 32,
    parameter int MEM_DEPTH = 64
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic [31:0]                  instrWord,
    input  logic                         newInstr,
    output logic                         busy,
    output logic                         done,
    output logic                         illegal,
    output logic                         overrun,
    input  logic [$clog2(MEM_DEPTH)-1:0] hostAddr,
    input  logic [DATA_W-1:0]            hostWrData,
    input  logic                         hostWe,
    output logic [DATA_W-1:0]            hostRdData
);
    localparam int AW = $clog2(MEM_DEPTH);
    localparam int RW = $clog2(REG_COUNT);

    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
    typedef enum logic [2:0] {A_ADD, A_SUB, A_AND, A_OR, A_NOR, A_SLT} alu_t;

    state_t            r_state, w_state_nxt;
    logic [31:0]       r_instr;
    logic              r_ni_q, r_busy, r_done, r_illegal, r_overrun, r_bad;
    logic [DATA_W-1:0] r_a, r_b, r_res, r_ld, r_host_rd;
    logic [DATA_W-1:0] r_regs [REG_COUNT];
    logic [DATA_W-1:0] r_mem [MEM_DEPTH];

    logic [5:0]        w_op, w_fn;
    logic [4:0]        w_rs, w_rt, w_rd, w_dst;
    logic [15:0]       w_imm;
    logic              w_ok, w_imm_op, w_zext, w_rtype, w_lw, w_sw;
    alu_t              w_alu;
    logic              w_rs_oob, w_rt_oob, w_rd_oob, w_bad;
    logic [DATA_W-1:0] w_imm_s, w_imm_z, w_rs_val, w_rt_val, w_ea;
    logic [DATA_W-1:0] w_opb, w_alu_y, w_wb_data;
    logic [AW-1:0]     w_mem_addr;
    logic              w_rise, w_accept, w_fin, w_fin_ill, w_mem_we, w_reg_we;

    assign w_op  = r_instr[31:26];
    assign w_rs  = r_instr[25:21];
    assign w_rt  = r_instr[20:16];
    assign w_rd  = r_instr[15:11];
    assign w_fn  = r_instr[5:0];
    assign w_imm = r_instr[15:0];

    always_comb begin
        w_ok     = 1'b1;
        w_alu    = A_ADD;
        w_imm_op = 1'b0;
        w_zext   = 1'b0;
        w_rtype  = 1'b0;
        w_lw     = 1'b0;
        w_sw     = 1'b0;
        case (w_op)
            6'b000000: begin
                w_rtype = 1'b1;
                case (w_fn)
                    6'b100000: w_alu = A_ADD;
                    6'b100010: w_alu = A_SUB;
                    6'b100100: w_alu = A_AND;
                    6'b100101: w_alu = A_OR;
                    6'b100111: w_alu = A_NOR;
                    6'b101010: w_alu = A_SLT;
                    default:   w_ok  = 1'b0;
                endcase
            end
            6'b001000: w_imm_op = 1'b1;
            6'b001100: begin w_imm_op = 1'b1; w_zext = 1'b1; w_alu = A_AND; end
            6'b001101: begin w_imm_op = 1'b1; w_zext = 1'b1; w_alu = A_OR;  end
            6'b100011: begin w_imm_op = 1'b1; w_lw = 1'b1; end
            6'b101011: begin w_imm_op = 1'b1; w_sw = 1'b1; end
            default:   w_ok = 1'b0;
        endcase
    end

    assign w_imm_s  = DATA_W'($signed(w_imm));
    assign w_imm_z  = DATA_W'(w_imm);
    assign w_dst    = w_rtype ? w_rd : w_rt;
    assign w_rs_oob = int'(w_rs) >= REG_COUNT;
    assign w_rt_oob = int'(w_rt) >= REG_COUNT;
    assign w_rd_oob = int'(w_rd) >= REG_COUNT;
    assign w_rs_val = w_rs_oob ? '0 : r_regs[w_rs[RW-1:0]];
    assign w_rt_val = w_rt_oob ? '0 : r_regs[w_rt[RW-1:0]];
    // Address bound is checked on the full-width sum so negative offsets trap
    assign w_ea     = w_rs_val + w_imm_s;
    assign w_bad    = !w_ok || w_rs_oob || w_rt_oob || (w_rtype && w_rd_oob) ||
                      ((w_lw || w_sw) && (w_ea >= DATA_W'(MEM_DEPTH)));

    assign w_opb = w_imm_op ? (w_zext ? w_imm_z : w_imm_s) : r_b;

    always_comb begin
        case (w_alu)
            A_SUB:   w_alu_y = r_a - w_opb;
            A_AND:   w_alu_y = r_a & w_opb;
            A_OR:    w_alu_y = r_a | w_opb;
            A_NOR:   w_alu_y = ~(r_a | w_opb);
            A_SLT:   w_alu_y = DATA_W'($signed(r_a) < $signed(w_opb));
            default: w_alu_y = r_a + w_opb;
        endcase
    end

    assign w_rise     = newInstr & ~r_ni_q;
    assign w_mem_addr = r_res[AW-1:0];
    assign w_wb_data  = w_lw ? r_ld : r_res;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_fin       = 1'b0;
        w_fin_ill   = 1'b0;
        w_mem_we    = 1'b0;
        w_reg_we    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rise) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_DECODE;
                end
            end
            S_DECODE: w_state_nxt = S_EXEC;
            S_EXEC: begin
                if (r_bad) begin
                    w_fin       = 1'b1;
                    w_fin_ill   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_lw || w_sw) begin
                    w_state_nxt = S_MEM;
                end else begin
                    w_state_nxt = S_WB;
                end
            end
            S_MEM: begin
                if (w_sw) begin
                    w_mem_we    = 1'b1;
                    w_fin       = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_WB;
                end
            end
            S_WB: begin
                w_reg_we    = 1'b1;
                w_fin       = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_instr   <= '0;
            r_ni_q    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            r_overrun <= 1'b0;
            r_bad     <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_res     <= '0;
            r_host_rd <= '0;
            for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
        end else begin
            r_ni_q    <= newInstr;
            r_done    <= w_fin;
            r_illegal <= w_fin_ill;
            r_host_rd <= r_mem[hostAddr];
            if (w_rise && r_busy) r_overrun <= 1'b1;
            if (w_accept) begin
                r_instr <= instrWord;
                r_busy  <= 1'b1;
            end else if (w_fin) begin
                r_busy  <= 1'b0;
            end
            if (r_state == S_DECODE) begin
                r_a   <= w_rs_val;
                r_b   <= w_rt_val;
                r_bad <= w_bad;
            end
            if (r_state == S_EXEC) r_res <= w_alu_y;
            if (w_reg_we && w_dst != 5'd0) r_regs[w_dst[RW-1:0]] <= w_wb_data;
        end
    end

    // Memory survives reset; host writes only land while idle
    always_ff @(posedge Clk) begin
        if (hostWe && !r_busy) r_mem[hostAddr] <= hostWrData;
        if (w_mem_we)          r_mem[w_mem_addr] <= r_b;
        r_ld <= r_mem[w_mem_addr];
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign illegal    = r_illegal;
    assign overrun    = r_overrun;
    assign hostRdData = r_host_rd;
endmodule

// File: tb/tb_mipscpu_mc.sv
// tb_mipscpu_mc: directed bench for mipscpu_mc, default build plus
// a DATA_W=16 / REG_COUNT=8 / MEM_DEPTH=16 build sharing the inputs.
module tb_mipscpu_mc;
    localparam int OP_R = 0, OP_ADDI = 8, OP_ANDI = 12, OP_ORI = 13;
    localparam int OP_LW = 35, OP_SW = 43;
    localparam int F_ADD = 32, F_SUB = 34, F_AND = 36, F_OR = 37;
    localparam int F_NOR = 39, F_SLT = 42;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] instrWord;
    logic        newInstr;
    logic [5:0]  hostAddr;
    logic [31:0] hostWrData;
    logic        hostWe;
    logic        busy_a, done_a, ill_a, ovr_a;
    logic [31:0] rd_a;
    logic        busy_b, done_b, ill_b, ovr_b;
    logic [15:0] rd_b;
    logic        sel = 1'b0;
    logic        busy_s, done_s, ill_s, ovr_s;
    logic [31:0] rd_s;
    int          errors = 0;
    int          checks = 0;

    always #5 Clk = ~Clk;

    assign busy_s = sel ? busy_b : busy_a;
    assign done_s = sel ? done_b : done_a;
    assign ill_s  = sel ? ill_b  : ill_a;
    assign ovr_s  = sel ? ovr_b  : ovr_a;
    assign rd_s   = sel ? {16'h0, rd_b} : rd_a;

    mipscpu_mc u_a (
        .Clk(Clk), .Reset(Reset), .instrWord(instrWord), .newInstr(newInstr),
        .busy(busy_a), .done(done_a), .illegal(ill_a), .overrun(ovr_a),
        .hostAddr(hostAddr), .hostWrData(hostWrData), .hostWe(hostWe),
        .hostRdData(rd_a)
    );

    mipscpu_mc #(.DATA_W(16), .REG_COUNT(8), .MEM_DEPTH(16)) u_b (
        .Clk(Clk), .Reset(Reset), .instrWord(instrWord), .newInstr(newInstr),
        .busy(busy_b), .done(done_b), .illegal(ill_b), .overrun(ovr_b),
        .hostAddr(hostAddr[3:0]), .hostWrData(hostWrData[15:0]), .hostWe(hostWe),
        .hostRdData(rd_b)
    );

    function automatic logic [31:0] rr(input int rs, input int rt, input int rd, input int fn);
        return {6'b0, 5'(rs), 5'(rt), 5'(rd), 5'b0, 6'(fn)};
    endfunction

    function automatic logic [31:0] ii(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic hwrite(input int a, input logic [31:0] d);
        hostAddr = 6'(a); hostWrData = d; hostWe = 1'b1;
        @(negedge Clk);
        hostWe = 1'b0;
    endtask

    task automatic hread(input int a, output logic [31:0] d);
        hostAddr = 6'(a);
        @(negedge Clk);
        d = rd_s;
    endtask

    // Returns edges from accept to the done pulse, or -1 on timeout
    task automatic issue(input logic [31:0] iw, output int lat, output logic ill);
        lat = -1; ill = 1'b0;
        instrWord = iw; newInstr = 1'b1;
        @(negedge Clk);
        newInstr = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge Clk);
            if (done_s === 1'b1) begin lat = k; ill = ill_s; break; end
        end
    endtask

    task automatic test_reset();
        Reset = 1'b0; newInstr = 1'b0; hostWe = 1'b0;
        instrWord = '0; hostAddr = '0; hostWrData = '0;
        repeat (2) @(negedge Clk);
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy_a); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done_a); end
        checks++; if (ill_a !== 1'b0) begin errors++; $display("FAIL reset_illegal got=%b want=0", ill_a); end
        checks++; if (ovr_a !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b want=0", ovr_a); end
        checks++; if (rd_a !== 32'h0) begin errors++; $display("FAIL reset_hostRd got=%h want=0", rd_a); end
        checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL reset_busy_b got=%b want=0", busy_b); end
        Reset = 1'b1;
        @(negedge Clk);
    endtask

    task automatic test_load_add_sub_store();
        logic [31:0] prog [6];
        int          exp_lat [6];
        int          lat;
        logic        ill;
        logic [31:0] d;
        hwrite(0, 10); hwrite(1, 22); hwrite(2, 6);
        prog = '{ii(OP_LW,0,1,0), ii(OP_LW,0,2,1), ii(OP_LW,0,3,2),
                 rr(1,2,4,F_ADD), rr(4,3,4,F_SUB), ii(OP_SW,0,4,3)};
        exp_lat = '{4, 4, 4, 3, 3, 3};
        for (int i = 0; i < 6; i++) begin
            issue(prog[i], lat, ill);
            checks++;
            if (lat !== exp_lat[i] || ill !== 1'b0)
                begin errors++; $display("FAIL lass_step%0d lat=%0d ill=%b want lat=%0d ill=0", i, lat, ill, exp_lat[i]); end
        end
        hread(3, d);
        checks++; if (d !== 32'd26) begin errors++; $display("FAIL lass_mem3 got=%0d want=26", d); end
    endtask

    task automatic test_logic_compare();
        logic [31:0] prog [16];
        logic [31:0] exp_mem [6];
        int          lat;
        logic        ill;
        logic [31:0] d;
        hwrite(0, 13); hwrite(1, 1); hwrite(2, 3);
        prog = '{ii(OP_LW,0,1,0), ii(OP_LW,0,2,1), ii(OP_LW,0,3,2),
                 rr(1,3,4,F_AND), rr(4,2,4,F_OR), ii(OP_SW,0,4,4),
                 rr(2,1,5,F_SLT), ii(OP_SW,0,5,5),
                 rr(0,0,6,F_NOR), ii(OP_SW,0,6,6),
                 ii(OP_ORI,0,7,32'h8000), ii(OP_SW,0,7,7),
                 ii(OP_ADDI,0,8,32'hFFFF), ii(OP_SW,0,8,8),
                 rr(8,0,9,F_SLT), ii(OP_SW,0,9,9)};
        for (int i = 0; i < 16; i++) begin
            issue(prog[i], lat, ill);
            checks++;
            if (lat !== ((i < 3) ? 4 : 3) || ill !== 1'b0)
                begin errors++; $display("FAIL logic_step%0d lat=%0d ill=%b want lat=%0d ill=0", i, lat, ill, (i < 3) ? 4 : 3); end
        end
        exp_mem = '{32'h1, 32'h1, 32'hFFFF_FFFF, 32'h8000, 32'hFFFF_FFFF, 32'h1};
        for (int i = 0; i < 6; i++) begin
            hread(4 + i, d);
            checks++;
            if (d !== exp_mem[i]) begin errors++; $display("FAIL logic_mem%0d got=%h want=%h", 4 + i, d, exp_mem[i]); end
        end
    endtask

    task automatic test_illegal();
        logic [31:0] prog [10];
        int          exp_lat [10];
        logic        exp_ill [10];
        int          lat;
        logic        ill;
        logic [31:0] d;
        hwrite(10, 32'h77); hwrite(12, 32'h77); hwrite(63, 32'h55);
        prog = '{{6'b000010, 26'h0}, rr(1,2,10,0), ii(OP_LW,0,10,64),
                 ii(OP_SW,0,2,64), ii(OP_LW,8,10,65), ii(OP_LW,0,10,32'hFFFF),
                 ii(OP_LW,0,11,63), ii(OP_SW,0,10,10),
                 ii(OP_ADDI,0,0,5), ii(OP_SW,0,0,12)};
        exp_lat = '{2, 2, 2, 2, 2, 2, 4, 3, 3, 3};
        exp_ill = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
        for (int i = 0; i < 10; i++) begin
            issue(prog[i], lat, ill);
            checks++;
            if (lat !== exp_lat[i] || ill !== exp_ill[i])
                begin errors++; $display("FAIL illegal_step%0d lat=%0d ill=%b want lat=%0d ill=%b", i, lat, ill, exp_lat[i], exp_ill[i]); end
        end
        hread(10, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL illegal_reg10 got=%h want=0", d); end
        hread(0, d);
        checks++; if (d !== 32'd13) begin errors++; $display("FAIL illegal_mem0 got=%h want=d", d); end
        hread(12, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL zero_reg got=%h want=0", d); end
    endtask

    task automatic test_handshake();
        int          cnt;
        int          lat;
        logic        ill;
        logic [31:0] d;
        cnt = 0;
        instrWord = ii(OP_ADDI,0,12,7); newInstr = 1'b1;
        for (int k = 0; k < 14; k++) begin
            @(negedge Clk);
            if (done_s === 1'b1) cnt++;
            if (k == 9) newInstr = 1'b0;
        end
        checks++; if (cnt !== 1) begin errors++; $display("FAIL held_strobe dones=%0d want=1", cnt); end
        issue(ii(OP_SW,0,12,12), lat, ill);
        hread(12, d);
        checks++; if (d !== 32'd7) begin errors++; $display("FAIL held_result got=%0d want=7", d); end

        hwrite(14, 32'h11);
        checks++; if (ovr_s !== 1'b0) begin errors++; $display("FAIL overrun_pre got=%b want=0", ovr_s); end
        cnt = 0;
        instrWord = ii(OP_ADDI,0,13,9); newInstr = 1'b1;
        @(negedge Clk);
        newInstr = 1'b0;
        instrWord = ii(OP_ADDI,0,13,3);
        hostAddr = 6'd14; hostWrData = 32'hAB; hostWe = 1'b1;
        @(negedge Clk);
        hostWe = 1'b0; newInstr = 1'b1;
        @(negedge Clk);
        newInstr = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge Clk);
            if (done_s === 1'b1) cnt++;
        end
        checks++; if (cnt !== 1) begin errors++; $display("FAIL overrun_dones got=%0d want=1", cnt); end
        checks++; if (ovr_s !== 1'b1) begin errors++; $display("FAIL overrun_flag got=%b want=1", ovr_s); end
        issue(ii(OP_SW,0,13,13), lat, ill);
        hread(13, d);
        checks++; if (d !== 32'd9) begin errors++; $display("FAIL overrun_ignored got=%0d want=9", d); end
        hread(14, d);
        checks++; if (d !== 32'h11) begin errors++; $display("FAIL busy_host_write got=%h want=11", d); end
    endtask

    task automatic test_simultaneous();
        int          lat;
        logic        ill;
        logic [31:0] d;
        hwrite(20, 32'h01);
        lat = -1;
        hostAddr = 6'd20; hostWrData = 32'h3C; hostWe = 1'b1;
        instrWord = ii(OP_LW,0,15,20); newInstr = 1'b1;
        @(negedge Clk);
        hostWe = 1'b0; newInstr = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge Clk);
            if (done_s === 1'b1) begin lat = k; break; end
        end
        checks++; if (lat !== 4) begin errors++; $display("FAIL accept_hostwr_lat got=%0d want=4", lat); end
        issue(ii(OP_SW,0,15,21), lat, ill);
        hread(21, d);
        checks++; if (d !== 32'h3C) begin errors++; $display("FAIL accept_hostwr_data got=%h want=3c", d); end

        hwrite(22, 32'h99);
        hostAddr = 6'd22;
        issue(ii(OP_SW,0,1,22), lat, ill);
        checks++; if (rd_s !== 32'h99) begin errors++; $display("FAIL rd_during_wr got=%h want=99", rd_s); end
        @(negedge Clk);
        checks++; if (rd_s !== 32'd13) begin errors++; $display("FAIL rd_after_wr got=%h want=d", rd_s); end
    endtask

    task automatic test_reset_mid_lw();
        int          cnt;
        int          lat;
        logic        ill;
        logic [31:0] d;
        hwrite(30, 32'h5A); hwrite(31, 32'hEE);
        instrWord = ii(OP_LW,0,16,30); newInstr = 1'b1;
        @(negedge Clk);
        newInstr = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        #1;
        checks++; if (busy_s !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b want=0", busy_s); end
        checks++; if (done_s !== 1'b0) begin errors++; $display("FAIL midrst_done got=%b want=0", done_s); end
        checks++; if (ill_s !== 1'b0) begin errors++; $display("FAIL midrst_illegal got=%b want=0", ill_s); end
        checks++; if (ovr_s !== 1'b0) begin errors++; $display("FAIL midrst_overrun got=%b want=0", ovr_s); end
        checks++; if (rd_s !== 32'h0) begin errors++; $display("FAIL midrst_hostRd got=%h want=0", rd_s); end
        @(negedge Clk);
        Reset = 1'b1;
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clk);
            if (done_s === 1'b1) cnt++;
        end
        checks++; if (cnt !== 0) begin errors++; $display("FAIL midrst_no_done got=%0d want=0", cnt); end
        hread(30, d);
        checks++; if (d !== 32'h5A) begin errors++; $display("FAIL midrst_mem30 got=%h want=5a", d); end
        hread(3, d);
        checks++; if (d !== 32'd26) begin errors++; $display("FAIL midrst_mem3 got=%0d want=26", d); end
        issue(ii(OP_SW,0,16,31), lat, ill);
        hread(31, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL midrst_reg16 got=%h want=0", d); end
    endtask

    task automatic test_param_sweep();
        logic [31:0] prog [13];
        int          exp_lat [13];
        logic        exp_ill [13];
        int          lat;
        logic        ill;
        logic [31:0] d;
        sel = 1'b1;
        hwrite(0, 32'hFFFF); hwrite(1, 32'h1); hwrite(2, 32'h1234); hwrite(15, 32'h0);
        prog = '{ii(OP_LW,0,1,0), ii(OP_LW,0,2,1), rr(1,2,3,F_ADD), ii(OP_SW,0,3,2),
                 rr(0,2,5,F_SUB), ii(OP_SW,0,5,3), rr(1,0,6,F_SLT), ii(OP_SW,0,6,4),
                 rr(1,8,3,F_ADD), rr(1,2,8,F_ADD), ii(OP_LW,0,4,15), ii(OP_LW,0,4,16),
                 ii(OP_ANDI,1,7,32'hF0F0)};
        exp_lat = '{4, 4, 3, 3, 3, 3, 3, 3, 2, 2, 4, 2, 3};
        exp_ill = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0};
        for (int i = 0; i < 13; i++) begin
            issue(prog[i], lat, ill);
            checks++;
            if (lat !== exp_lat[i] || ill !== exp_ill[i])
                begin errors++; $display("FAIL sweep_step%0d lat=%0d ill=%b want lat=%0d ill=%b", i, lat, ill, exp_lat[i], exp_ill[i]); end
        end
        issue(ii(OP_SW,0,7,5), lat, ill);
        hread(2, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL sweep_wrap got=%h want=0", d); end
        hread(3, d);
        checks++; if (d !== 32'hFFFF) begin errors++; $display("FAIL sweep_sub got=%h want=ffff", d); end
        hread(4, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL sweep_slt got=%h want=1", d); end
        hread(5, d);
        checks++; if (d !== 32'hF0F0) begin errors++; $display("FAIL sweep_andi got=%h want=f0f0", d); end
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_add_sub_store();
        test_logic_compare();
        test_illegal();
        test_handshake();
        test_simultaneous();
        test_reset_mid_lw();
        test_param_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
